// File: rtl/scpu_fetch_unit_if.sv
// Instruction-memory fetch bus between scpu_fetch_unit (master) and the instruction memory (slave).
// imem_rdata is only meaningful in the cycle imem_ready is high.
interface scpu_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;

  modport master (output imem_req, output imem_addr, input imem_rdata, input imem_ready);
  modport slave  (input imem_req, input imem_addr, output imem_rdata, output imem_ready);
endinterface

// File: rtl/scpu_fetch_unit.sv
// Fetch stage feeding SCPU_ctrl: PC, IR and decode fields, next-PC selection from Jump/Branch/zero.
// Error flags are sticky; the unit parks in S_ERR until rst.
module scpu_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [7:0]  WAIT_LIMIT = 8'd255
) (
  input  logic                     clk,
  input  logic                     rst,
  scpu_fetch_unit_if.master        imem,
  input  logic                     commit,
  input  logic                     Jump,
  input  logic                     Branch,
  input  logic                     zero,
  input  logic [31:0]              imm,
  output logic [31:0]              inst,
  output logic                     inst_valid,
  output logic [31:0]              pc_out,
  output logic [31:0]              pc_plus4,
  output logic [4:0]               OPcode,
  output logic [2:0]               Fun3,
  output logic                     Fun7,
  output logic                     fetch_err,
  output logic                     misalign_err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_ERR   = 2'd3
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_ir;
  logic [7:0]  r_wait_cnt;
  logic        r_imem_req;
  logic        r_inst_valid;
  logic        r_fetch_err;
  logic        r_misalign_err;

  logic        w_taken;
  logic [31:0] w_next_pc;
  logic [7:0]  w_wait_next;

  assign w_taken     = Jump | (Branch & zero);
  assign w_next_pc   = w_taken ? (r_pc + imm) : (r_pc + 32'd4);
  assign w_wait_next = r_wait_cnt + 8'd1;

  assign imem.imem_req  = r_imem_req;
  assign imem.imem_addr = r_pc;
  assign inst           = r_ir;
  assign inst_valid     = r_inst_valid;
  assign pc_out         = r_pc;
  assign pc_plus4       = r_pc + 32'd4;
  assign OPcode         = r_ir[6:2];
  assign Fun3           = r_ir[14:12];
  assign Fun7           = r_ir[30];
  assign fetch_err      = r_fetch_err;
  assign misalign_err   = r_misalign_err;

  // Fetch/execute sequencer; req and inst_valid are registered alongside the state they reflect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_pc           <= RESET_PC;
      r_ir           <= 32'h0000_0013;
      r_wait_cnt     <= 8'd0;
      r_imem_req     <= 1'b0;
      r_inst_valid   <= 1'b0;
      r_fetch_err    <= 1'b0;
      r_misalign_err <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_state    <= S_FETCH;
          r_imem_req <= 1'b1;
        end
        S_FETCH: begin
          // A response arriving in the limit cycle still counts as a successful fetch.
          if (imem.imem_ready) begin
            r_ir         <= imem.imem_rdata;
            r_wait_cnt   <= 8'd0;
            r_state      <= S_EXEC;
            r_imem_req   <= 1'b0;
            r_inst_valid <= 1'b1;
          end else begin
            r_wait_cnt <= w_wait_next;
            if ((WAIT_LIMIT != 8'd0) && (w_wait_next == WAIT_LIMIT)) begin
              r_fetch_err <= 1'b1;
              r_state     <= S_ERR;
              r_imem_req  <= 1'b0;
            end else begin
              r_state <= S_FETCH;
            end
          end
        end
        S_EXEC: begin
          if (commit) begin
            r_inst_valid <= 1'b0;
            if (w_next_pc[1:0] != 2'b00) begin
              r_misalign_err <= 1'b1;
              r_state        <= S_ERR;
            end else begin
              r_pc       <= w_next_pc;
              r_state    <= S_FETCH;
              r_imem_req <= 1'b1;
            end
          end else begin
            r_state <= S_EXEC;
          end
        end
        S_ERR: begin
          r_state      <= S_ERR;
          r_imem_req   <= 1'b0;
          r_inst_valid <= 1'b0;
        end
        default: begin
          r_state      <= S_ERR;
          r_imem_req   <= 1'b0;
          r_inst_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_scpu_fetch_unit.sv
// Self-checking bench for scpu_fetch_unit: transaction-level PC/IR model plus per-cycle output compare.
module tb_scpu_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int          LIMIT  = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        commit, Jump, Branch, zero;
  logic [31:0] imm;
  logic [31:0] inst, pc_out, pc_plus4;
  logic        inst_valid, Fun7, fetch_err, misalign_err;
  logic [4:0]  OPcode;
  logic [2:0]  Fun3;

  scpu_fetch_unit_if bus ();

  scpu_fetch_unit #(.RESET_PC(RST_PC), .WAIT_LIMIT(8'd4)) dut (
    .clk(clk), .rst(rst), .imem(bus), .commit(commit), .Jump(Jump), .Branch(Branch),
    .zero(zero), .imm(imm), .inst(inst), .inst_valid(inst_valid), .pc_out(pc_out),
    .pc_plus4(pc_plus4), .OPcode(OPcode), .Fun3(Fun3), .Fun7(Fun7),
    .fetch_err(fetch_err), .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  // Model: architectural PC/IR plus which outputs must currently be asserted.
  logic [31:0] m_pc, m_ir;
  logic        e_req, e_valid, e_ferr, e_merr;
  bit          chk_en = 1'b0;
  int          total = 0;
  int          bad = 0;

  task automatic cmp(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", n, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("imem_req", {31'd0, bus.imem_req}, {31'd0, e_req});
      cmp("imem_addr", bus.imem_addr, m_pc);
      cmp("inst_valid", {31'd0, inst_valid}, {31'd0, e_valid});
      cmp("inst", inst, m_ir);
      cmp("pc_out", pc_out, m_pc);
      cmp("pc_plus4", pc_plus4, m_pc + 32'd4);
      cmp("OPcode", {27'd0, OPcode}, {27'd0, m_ir[6:2]});
      cmp("Fun3", {29'd0, Fun3}, {29'd0, m_ir[14:12]});
      cmp("Fun7", {31'd0, Fun7}, {31'd0, m_ir[30]});
      cmp("fetch_err", {31'd0, fetch_err}, {31'd0, e_ferr});
      cmp("misalign_err", {31'd0, misalign_err}, {31'd0, e_merr});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Asserts rst away from the clock edge, checks reset values, then releases; ends in first FETCH cycle.
  task automatic do_reset();
    rst = 1'b1;
    commit = 1'b0; Jump = 1'b0; Branch = 1'b0; zero = 1'b0; imm = 32'd0;
    bus.imem_ready = 1'b0; bus.imem_rdata = 32'd0;
    m_pc = RST_PC; m_ir = 32'h0000_0013;
    e_req = 1'b0; e_valid = 1'b0; e_ferr = 1'b0; e_merr = 1'b0;
    #1;
    cmp("rst_pc", pc_out, RST_PC);
    cmp("rst_ir", inst, 32'h0000_0013);
    cmp("rst_opcode", {27'd0, OPcode}, 32'd4);
    cmp("rst_flags", {30'd0, fetch_err, misalign_err}, 32'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    e_req = 1'b1;
  endtask

  // Holds imem_ready low for 'delay' FETCH cycles, then returns 'word'; a long delay trips the timeout.
  task automatic fetch(input int delay, input logic [31:0] word, output bit err);
    err = 1'b0;
    for (int i = 0; i <= delay; i++) begin
      bus.imem_ready = (i == delay);
      bus.imem_rdata = (i == delay) ? word : $urandom;
      commit = 1'($urandom);
      tick();
      if (i == delay) begin
        m_ir = word; e_req = 1'b0; e_valid = 1'b1;
      end else if (i + 1 == LIMIT) begin
        e_ferr = 1'b1; e_req = 1'b0; err = 1'b1;
        break;
      end
    end
    bus.imem_ready = 1'b0;
    commit = 1'b0;
  endtask

  // Waits 'hold' cycles with noise on ignored inputs, then commits with the given control values.
  task automatic exec(input int hold, input logic j, input logic b, input logic z,
                      input logic [31:0] im, output bit err);
    logic [31:0] tgt;
    err = 1'b0;
    for (int i = 0; i < hold; i++) begin
      commit = 1'b0;
      Jump = 1'($urandom); Branch = 1'($urandom); zero = 1'($urandom); imm = $urandom;
      bus.imem_ready = 1'($urandom); bus.imem_rdata = $urandom;
      tick();
    end
    bus.imem_ready = 1'b0;
    commit = 1'b1; Jump = j; Branch = b; zero = z; imm = im;
    tick();
    tgt = (j || (b && z)) ? m_pc + im : m_pc + 32'd4;
    e_valid = 1'b0;
    if (tgt[1:0] != 2'b00) begin
      e_merr = 1'b1; err = 1'b1;
    end else begin
      m_pc = tgt; e_req = 1'b1;
    end
    commit = 1'b0; Jump = 1'b0; Branch = 1'b0;
  endtask

  task automatic err_hold();
    for (int i = 0; i < 3; i++) begin
      commit = 1'b1; Jump = 1'($urandom); imm = $urandom;
      bus.imem_ready = 1'b1; bus.imem_rdata = $urandom;
      tick();
    end
    commit = 1'b0; bus.imem_ready = 1'b0;
  endtask

  initial begin
    bit e;
    int dly;
    logic [31:0] im;
    #1;
    chk_en = 1'b1;

    // Latency and decode of the first instruction.
    do_reset();
    cmp("t1_req_cycle1", {31'd0, bus.imem_req}, 32'd1);
    fetch(0, 32'h001100B3, e);
    cmp("t1_valid_cycle2", {31'd0, inst_valid}, 32'd1);
    cmp("t1_opcode", {27'd0, OPcode}, 32'h0000_000C);
    cmp("t1_fun3_fun7", {28'd0, Fun3, Fun7}, 32'd0);
    cmp("t1_pc", pc_out, 32'd0);

    // Straight-line code.
    exec(1, 1'b0, 1'b0, 1'b0, 32'd8, e);
    cmp("t2_addr4", bus.imem_addr, 32'h4);
    fetch(2, $urandom, e);
    exec(0, 1'b0, 1'b0, 1'b0, 32'd0, e);
    cmp("t2_addr8", bus.imem_addr, 32'h8);
    fetch(1, $urandom, e);
    exec(2, 1'b0, 1'b1, 1'b0, 32'd64, e);
    fetch(0, $urandom, e);
    exec(0, 1'b0, 1'b0, 1'b1, 32'd64, e);
    cmp("t2_addr10", bus.imem_addr, 32'h10);

    // Branch taken and not taken from 0x10.
    fetch(0, 32'hFE108AE3, e);
    exec(0, 1'b0, 1'b1, 1'b1, -32'sd12, e);
    cmp("t3_beq_taken", bus.imem_addr, 32'h4);
    for (int k = 0; k < 3; k++) begin
      fetch(0, $urandom, e);
      exec(0, 1'b0, 1'b0, 1'b0, 32'd0, e);
    end
    fetch(0, 32'hFE108AE3, e);
    exec(0, 1'b0, 1'b1, 1'b0, -32'sd12, e);
    cmp("t3_beq_not_taken", bus.imem_addr, 32'h14);

    // jal at 0x200, then 32-bit wrap.
    fetch(0, $urandom, e);
    exec(0, 1'b1, 1'b0, 1'b0, 32'h1EC, e);
    cmp("t4_addr200", bus.imem_addr, 32'h200);
    fetch(0, 32'hF9DFF06F, e);
    cmp("t4_pc_plus4", pc_plus4, 32'h204);
    cmp("t4_jal_opcode", {27'd0, OPcode}, 32'h0000_001B);
    exec(1, 1'b1, 1'b0, 1'b0, -32'sd100, e);
    cmp("t4_jal_target", bus.imem_addr, 32'h19C);
    fetch(0, $urandom, e);
    exec(0, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFC - 32'h19C, e);
    fetch(0, $urandom, e);
    exec(0, 1'b0, 1'b0, 1'b0, 32'd0, e);
    cmp("wrap_to_zero", bus.imem_addr, 32'h0);

    // Misaligned jump target.
    fetch(0, $urandom, e);
    exec(0, 1'b1, 1'b0, 1'b0, 32'd2, e);
    cmp("t6_misalign", {31'd0, misalign_err}, 32'd1);
    cmp("t6_pc_held", pc_out, 32'h0);
    err_hold();
    do_reset();

    // Fetch timeout, then a response exactly at the limit.
    fetch(6, 32'h0, e);
    cmp("t5_fetch_err", {31'd0, fetch_err}, 32'd1);
    cmp("t5_req_drop", {31'd0, bus.imem_req}, 32'd0);
    err_hold();
    cmp("t5_stays_err", {30'd0, fetch_err, bus.imem_req}, 32'd2);
    do_reset();
    fetch(3, 32'h00A00093, e);
    cmp("t5_ready_at_limit", {30'd0, fetch_err, inst_valid}, 32'd1);

    // Reset in the middle of a fetch.
    exec(0, 1'b0, 1'b0, 1'b0, 32'd0, e);
    bus.imem_ready = 1'b0;
    tick();
    do_reset();

    // Randomized instruction stream.
    for (int n = 0; n < 400; n++) begin
      dly = ($urandom_range(0, 11) == 0) ? 4 + $urandom_range(0, 2) : $urandom_range(0, 3);
      if ($urandom_range(0, 39) == 0) begin
        bus.imem_ready = 1'b0;
        tick();
        do_reset();
        continue;
      end
      fetch(dly, $urandom, e);
      if (e) begin
        err_hold();
        do_reset();
        continue;
      end
      im = $urandom;
      if ($urandom_range(0, 11) != 0) im[1:0] = 2'b00;
      exec($urandom_range(0, 3), 1'($urandom), 1'($urandom), 1'($urandom), im, e);
      if (e) begin
        err_hold();
        do_reset();
      end
    end

    @(posedge clk);
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
